// File: rtl/display_pkg.sv
// Shared constants for the hex 7-segment display controller.
// All segment and anode values are active-low (common-anode display).
package display_pkg;

    // Segment patterns for hex digits 0..F, bit0=a ... bit6=g, active-low.
    localparam logic [6:0] SEG7_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All segments dark.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // All anodes disabled.
    localparam logic [7:0] AN_OFF = 8'hFF;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; every nibble value has an entry so no default is needed.
    assign seg = SEG7_LUT[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// Latches a 32-bit value and scans it as 8 hex digits onto a common-anode
// 7-segment display, with per-slot dead time and optional leading-zero
// blanking. All outputs are registered and active-low.
//
// Capture interface: load_i is a plain strobe with no back-pressure; data_i
// is taken on every rising edge where load_i=1 (rst_i wins over load_i).
module hex_display_ctrl
    import display_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] data_i,
    input  logic        load_i,
    input  logic        blank_lz_i,
    input  logic [7:0]  dp_mask_i,
    output logic [7:0]  an_o,
    output logic [6:0]  seg_o,
    output logic        dp_o
);

    localparam int SW = $clog2(REFRESH_DIV);

    logic [31:0]   value_q;
    logic [SW-1:0] slot_cnt;
    logic [2:0]    digit_idx;

    logic [4:0]    nib_shift;
    logic [3:0]    cur_nibble;
    logic [31:0]   upper_bits;
    logic          lz_blank;
    logic [6:0]    dec_seg;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;
    logic          dp_d;

    // Capture register: holds the displayed value between load strobes.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= data_i;
        end
    end

    // Slot counter and digit index: one digit slot every REFRESH_DIV cycles,
    // digits visited 0..7 in order, blanked digits still take their slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else if (slot_cnt == SW'(REFRESH_DIV - 1)) begin
            slot_cnt <= '0;
            if (digit_idx == 3'(DIGITS - 1)) begin
                digit_idx <= '0;
            end else begin
                digit_idx <= digit_idx + 3'd1;
            end
        end else begin
            slot_cnt <= slot_cnt + SW'(1);
        end
    end

    // Nibble select and leading-zero detect: a digit is a leading zero when
    // it and every more significant nibble are zero; digit 0 always shows.
    assign nib_shift  = {digit_idx, 2'b00};
    assign cur_nibble = value_q[nib_shift +: 4];
    assign upper_bits = value_q >> nib_shift;
    assign lz_blank   = blank_lz_i && (digit_idx != 3'd0) && (upper_bits == 32'd0);

    hex_to_seg7 u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    // Next output values: segments follow the new digit straight away, while
    // the anode stays off for the first BLANK_CYCLES of the slot so the
    // previous digit's pattern never lights the new anode.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (!lz_blank) begin
            seg_d = dec_seg;
            dp_d  = ~dp_mask_i[digit_idx];
            if (slot_cnt >= SW'(BLANK_CYCLES)) begin
                an_d = ~(8'h01 << digit_idx);
            end
        end
    end

    // Output flops: glitch-free drive of the display pins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            an_o  <= AN_OFF;
            seg_o <= SEG_OFF;
            dp_o  <= 1'b1;
        end else begin
            an_o  <= an_d;
            seg_o <= seg_d;
            dp_o  <= dp_d;
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a short refresh slot
// (REFRESH_DIV=4, BLANK_CYCLES=1). Expected outputs come from hand-computed
// per-digit segment tables and the known slot timing.
module tb_hex_display_ctrl;

    localparam int RD = 4;
    localparam int BC = 1;

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        blank;
    logic [31:0] data;
    logic [7:0]  dp_mask;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    always #5 clk = ~clk;

    hex_display_ctrl #(
        .DIGITS       (8),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .data_i     (data),
        .load_i     (load),
        .blank_lz_i (blank),
        .dp_mask_i  (dp_mask),
        .an_o       (an),
        .seg_o      (seg),
        .dp_o       (dp)
    );

    int n_vec = 0;
    int n_err = 0;
    int tick  = -1;

    // Expected segment pattern per digit and whether that digit is lit.
    logic [6:0] exp_seg_d [8];
    logic       lit_d     [8];

    // Scoreboard entries: {an[7:0], seg[6:0], dp, dp_valid}
    logic [16:0] exp_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        tick++;
    endtask

    task automatic run_to(input int t);
        while (tick < t) step();
    endtask

    task automatic set_all_seg(input logic [6:0] v);
        for (int i = 0; i < 8; i++) begin
            exp_seg_d[i] = v;
            lit_d[i]     = 1'b1;
        end
    endtask

    // Build expected outputs for edges first..last from the digit tables,
    // then step through them and compare. Edge t shows slot t%RD of digit
    // (t/RD)%8 counted from the last reset release.
    task automatic check_range(input int first, input int last);
        logic [16:0] entry;
        run_to(first - 1);
        for (int t = first; t <= last; t++) begin
            int         s;
            int         d;
            logic [7:0] e_an;
            logic [6:0] e_seg;
            logic       e_dp;
            logic       e_dp_chk;
            s = t % RD;
            d = (t / RD) % 8;
            if (!lit_d[d]) begin
                e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_dp_chk = 1'b1;
            end else begin
                e_seg = exp_seg_d[d];
                if (s < BC) begin
                    e_an = 8'hFF; e_dp = 1'b1; e_dp_chk = 1'b0;
                end else begin
                    e_an = ~(8'h01 << d); e_dp = ~dp_mask[d]; e_dp_chk = 1'b1;
                end
            end
            exp_q.push_back({e_an, e_seg, e_dp, e_dp_chk});
        end
        for (int t = first; t <= last; t++) begin
            entry = exp_q.pop_front();
            step();
            check_val($sformatf("an t%0d", t), an, entry[16:9]);
            check_val($sformatf("seg t%0d", t), seg, entry[8:2]);
            if (entry[0]) check_val($sformatf("dp t%0d", t), dp, entry[1]);
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b1; data = 32'hFFFF_FFFF; blank = 1'b0; dp_mask = 8'h00;

        // 1. Reset held 3 cycles with a load pending: outputs dark throughout.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val("rst_an", an, 8'hFF);
            check_val("rst_seg", seg, 7'h7F);
            check_val("rst_dp", dp, 1'b1);
        end
        rst = 1'b0; load = 1'b0; tick = -1;
        set_all_seg(7'h40);
        check_range(0, 1);

        // 2. Full scan of 89ABCDEF, including the 7F -> FE wrap.
        load = 1'b1; data = 32'h89AB_CDEF;
        step();
        check_val("pre_load_seg", seg, 7'h40);
        load = 1'b0;
        exp_seg_d = '{7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00};
        check_range(3, 35);

        // 3. Leading-zero blanking on 00000A05, then on 0.
        blank = 1'b1;
        run_to(61);
        load = 1'b1; data = 32'h0000_0A05;
        step();
        load = 1'b0;
        set_all_seg(7'h7F);
        exp_seg_d[0] = 7'h12; exp_seg_d[1] = 7'h40; exp_seg_d[2] = 7'h08;
        for (int i = 3; i < 8; i++) lit_d[i] = 1'b0;
        check_range(63, 95);
        load = 1'b1; data = 32'h0;
        step();
        check_val("lz_old_seg", seg, 7'h12);
        load = 1'b0;
        exp_seg_d[0] = 7'h40;
        for (int i = 1; i < 8; i++) lit_d[i] = 1'b0;
        check_range(97, 127);

        // 4. Decimal point on digit 2 only.
        blank = 1'b0; dp_mask = 8'h04;
        set_all_seg(7'h40);
        check_range(128, 159);

        // 5. Mid-slot load: segment changes two edges after the strobe.
        run_to(160);
        load = 1'b1; data = 32'h0000_0001;
        step();
        check_val("ld_edge_seg", seg, 7'h40);
        check_val("ld_edge_an", an, 8'hFE);
        load = 1'b0; data = 32'hFFFF_FFFF;
        step();
        check_val("ld_next_seg", seg, 7'h79);
        check_val("ld_next_an", an, 8'hFE);
        exp_seg_d[0] = 7'h79;
        check_range(163, 211);

        // 6. Reset during digit 5's active phase restarts at digit 0.
        run_to(213);
        rst = 1'b1;
        step();
        check_val("mid_rst_an", an, 8'hFF);
        check_val("mid_rst_seg", seg, 7'h7F);
        check_val("mid_rst_dp", dp, 1'b1);
        rst = 1'b0; tick = -1;
        set_all_seg(7'h40);
        check_range(0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
